// File: rtl/mul8_mac_sched.sv
// mul8_mac_sched
// Sequencer and accumulator around the 8-bit multiplier on the CNN convolution
// path. A frame is one weight followed by LEN activations. Each activation is
// issued to the multiplier together with the held weight. The products come
// back MUL_LAT cycles later, and their sum is presented on a valid/ready port.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   iWt/iWtVld/oWtRdy        weight handshake (accepted only in IDLE)
//   iAct/iActVld/oActRdy     activation handshake (STREAM, until LEN issued)
//   oMulA/oMulB/oMulEn       multiplier operands and enable
//   iMulP                    multiplier product, two's complement
//   oAcc/oAccVld/iAccRdy     frame sum handshake
//   oBusy                    high whenever the sequencer is not idle
//
// state  | meaning
// IDLE   | waiting for a weight, oWtRdy high
// STREAM | accepting activations until LEN have been issued
// DRAIN  | waiting for the remaining products to return
// OUT    | sum presented, held until iAccRdy
module mul8_mac_sched #(
  parameter int LEN     = 128,
  parameter int MUL_LAT = 3,
  parameter int ACC_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       iWt,
  input  logic             iWtVld,
  output logic             oWtRdy,
  input  logic [7:0]       iAct,
  input  logic             iActVld,
  output logic             oActRdy,
  output logic [7:0]       oMulA,
  output logic [7:0]       oMulB,
  output logic             oMulEn,
  input  logic [15:0]      iMulP,
  output logic [ACC_W-1:0] oAcc,
  output logic             oAccVld,
  input  logic             iAccRdy,
  output logic             oBusy
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]        iss_cnt;
  logic [CNT_W-1:0]        ret_cnt;
  logic [MUL_LAT:0]        vld_pipe;
  logic [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic                    wt_take;
  logic                    act_take;
  logic                    tail;

  // Bit k of vld_pipe marks a product that is k+1 cycles old. The tail bit
  // lines up with the cycle in which that product is on iMulP.
  assign tail     = vld_pipe[MUL_LAT];
  assign prod_ext = ACC_W'($signed(iMulP));
  assign wt_take  = (state == IDLE) && iWtVld;
  assign act_take = oActRdy && iActVld;

  always_comb begin
    state_nxt = state;
    oWtRdy    = 1'b0;
    oActRdy   = 1'b0;
    oAccVld   = 1'b0;
    unique case (state)
      IDLE: begin
        oWtRdy = 1'b1;
        if (iWtVld) state_nxt = STREAM;
      end
      STREAM: begin
        oActRdy = (iss_cnt < LEN_C);
        if (iss_cnt == LEN_C || (iActVld && oActRdy && iss_cnt == LEN_C - 1'b1))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leave on the same edge that absorbs the last product, so the sum is
        // valid in the very next cycle.
        if (ret_cnt == LEN_C || (tail && ret_cnt == LEN_C - 1'b1))
          state_nxt = OUT;
      end
      OUT: begin
        oAccVld = 1'b1;
        if (iAccRdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      iss_cnt  <= '0;
      ret_cnt  <= '0;
      vld_pipe <= '0;
      acc      <= '0;
      oMulA    <= '0;
      oMulB    <= '0;
      oMulEn   <= 1'b0;
    end else begin
      state    <= state_nxt;
      vld_pipe <= {vld_pipe[MUL_LAT-1:0], act_take};
      oMulEn   <= act_take;
      if (act_take) begin
        oMulA   <= iAct;
        iss_cnt <= iss_cnt + 1'b1;
      end
      if (wt_take) begin
        oMulB   <= iWt;
        acc     <= '0;
        iss_cnt <= '0;
        ret_cnt <= '0;
      end else if (tail) begin
        acc     <= acc + prod_ext;
        ret_cnt <= ret_cnt + 1'b1;
      end
    end
  end

  assign oAcc  = acc;
  assign oBusy = (state != IDLE);

endmodule

// File: tb/tb_mul8_mac_sched.sv
module tb_mul8_mac_sched;

  localparam int LEN     = 4;
  localparam int MUL_LAT = 3;
  localparam int ACC_W   = 24;

  logic             clk;
  logic             rst;
  logic [7:0]       iWt;
  logic             iWtVld;
  logic             oWtRdy;
  logic [7:0]       iAct;
  logic             iActVld;
  logic             oActRdy;
  logic [7:0]       oMulA;
  logic [7:0]       oMulB;
  logic             oMulEn;
  logic [15:0]      iMulP;
  logic [ACC_W-1:0] oAcc;
  logic             oAccVld;
  logic             iAccRdy;
  logic             oBusy;

  mul8_mac_sched #(.LEN(LEN), .MUL_LAT(MUL_LAT), .ACC_W(ACC_W)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .iWt     (iWt),
    .iWtVld  (iWtVld),
    .oWtRdy  (oWtRdy),
    .iAct    (iAct),
    .iActVld (iActVld),
    .oActRdy (oActRdy),
    .oMulA   (oMulA),
    .oMulB   (oMulB),
    .oMulEn  (oMulEn),
    .iMulP   (iMulP),
    .oAcc    (oAcc),
    .oAccVld (oAccVld),
    .iAccRdy (iAccRdy),
    .oBusy   (oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int en_pulses = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Multiplier stand-in: signed product with MUL_LAT cycles of latency from
  // the operand registers. Idle slots carry random junk so the DUT must
  // rely on its own valid tracking.
  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] x, y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  logic [15:0] mpipe [MUL_LAT];
  initial for (int i = 0; i < MUL_LAT; i++) mpipe[i] = 16'h0;
  always @(posedge clk) begin
    mpipe[0] <= oMulEn ? smul(oMulA, oMulB) : 16'($urandom);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign iMulP = mpipe[MUL_LAT-1];

  // Reference model: frame phase from the handshake rules, the sum as a plain
  // integer, and the sum-valid time from the latency rule (valid MUL_LAT+1
  // edges after the last activation edge).
  int         m_phase;       // 0 idle, 1 stream, 2 drain, 3 out
  int         m_issued;
  int         m_drain_left;
  logic [7:0] m_a, m_b;
  logic       m_en;
  longint     m_sum;
  logic       m_zero_acc;
  logic       m_live = 1'b0;
  int         m_wi, m_ai;

  always @(posedge clk) begin
    if (!rst) begin
      m_phase    = 0;
      m_issued   = 0;
      m_en       = 1'b0;
      m_a        = 8'h0;
      m_b        = 8'h0;
      m_sum      = 0;
      m_zero_acc = 1'b1;
      m_live     = 1'b1;
    end else begin
      m_en = 1'b0;
      case (m_phase)
        0: if (iWtVld) begin
          m_b        = iWt;
          m_sum      = 0;
          m_issued   = 0;
          m_phase    = 1;
          m_zero_acc = 1'b0;
        end
        1: if (iActVld) begin
          m_a  = iAct;
          m_en = 1'b1;
          m_wi = $signed(m_b);
          m_ai = $signed(iAct);
          m_sum += longint'(m_wi * m_ai);
          m_issued++;
          if (m_issued == LEN) begin
            m_phase      = 2;
            m_drain_left = MUL_LAT + 1;
          end
        end
        2: begin
          m_drain_left--;
          if (m_drain_left == 0) m_phase = 3;
        end
        default: if (iAccRdy) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("wt_rdy",  {31'b0, oWtRdy},  {31'b0, m_phase == 0});
      check("act_rdy", {31'b0, oActRdy}, {31'b0, m_phase == 1});
      check("busy",    {31'b0, oBusy},   {31'b0, m_phase != 0});
      check("acc_vld", {31'b0, oAccVld}, {31'b0, m_phase == 3});
      check("mul_en",  {31'b0, oMulEn},  {31'b0, m_en});
      check("mul_b",   {24'b0, oMulB},   {24'b0, m_b});
      if (m_en) check("mul_a", {24'b0, oMulA}, {24'b0, m_a});
      if (m_phase == 3) check("acc_out", {8'b0, oAcc}, {8'b0, ACC_W'(m_sum)});
      if (m_zero_acc) begin
        check("acc_cleared",   {8'b0, oAcc},   32'h0);
        check("mul_a_cleared", {24'b0, oMulA}, 32'h0);
      end
      if (oMulEn === 1'b1) en_pulses++;
    end
  end

  logic [7:0] fr_acts [LEN];

  function automatic logic [ACC_W-1:0] frame_sum(input logic [7:0] w);
    int s, wi, ai;
    s  = 0;
    wi = $signed(w);
    for (int i = 0; i < LEN; i++) begin
      ai = $signed(fr_acts[i]);
      s += wi * ai;
    end
    return ACC_W'(s);
  endfunction

  // Runs one frame starting at a negedge and returns at a negedge after the
  // sum has been taken. gap_mode: 0 back-to-back, 1 every other cycle,
  // 2 random. lat is counted with the cycle right after the accepting edge
  // as cycle 1.
  task automatic run_frame(input logic [7:0] w, input int gap_mode, input int hold,
                           output logic [ACC_W-1:0] got, output int lat);
    int  budget, k, t, last;
    logic v, took;
    iAccRdy = (hold == 0);
    budget = 0;
    while (!oWtRdy && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("wt_rdy_wait", {31'b0, oWtRdy}, 32'h1);
    iWtVld = 1'b1;
    iWt    = w;
    @(negedge clk);
    iWtVld = 1'b0;
    iWt    = 8'($urandom);
    k = 0; t = 0; budget = 0; last = cyc;
    while (k < LEN && budget < 200) begin
      if (gap_mode == 1)      v = (t % 2 == 0);
      else if (gap_mode == 2) v = ($urandom_range(0, 2) != 0);
      else                    v = 1'b1;
      iActVld = v;
      iAct    = v ? fr_acts[k] : 8'($urandom);
      took    = v && oActRdy;
      if (took) k++;
      @(negedge clk);
      if (took) last = cyc;
      t++;
      budget++;
    end
    iActVld = 1'b0;
    check("acts_accepted", k, LEN);
    budget = 0;
    while (!oAccVld && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("acc_vld_wait", {31'b0, oAccVld}, 32'h1);
    lat = cyc - last + 1;
    got = oAcc;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        iWtVld = 1'b1;
        iWt    = 8'($urandom);
        @(negedge clk);
        check("acc_hold", {8'b0, oAcc}, {8'b0, got});
        check("wt_rdy_in_out", {31'b0, oWtRdy}, 32'h0);
      end
      iWtVld  = 1'b0;
      iAccRdy = 1'b1;
    end
    @(negedge clk);
    check("idle_after_ack", {31'b0, oWtRdy}, 32'h1);
  endtask

  logic [ACC_W-1:0] got;
  int               lat;
  logic [7:0]       rw;

  initial begin
    rst     = 1'b0;
    iWt     = 8'd5;
    iWtVld  = 1'b1;
    iAct    = 8'd7;
    iActVld = 1'b1;
    iAccRdy = 1'b1;

    // Reset held with both valids asserted
    repeat (3) @(negedge clk);
    check("rst_wt_rdy",  {31'b0, oWtRdy},  32'h1);
    check("rst_act_rdy", {31'b0, oActRdy}, 32'h0);
    check("rst_mul_en",  {31'b0, oMulEn},  32'h0);
    check("rst_mul_b",   {24'b0, oMulB},   32'h0);
    check("rst_acc",     {8'b0, oAcc},     32'h0);
    iWtVld  = 1'b0;
    iActVld = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    check("rel_wt_rdy", {31'b0, oWtRdy}, 32'h1);
    check("rel_busy",   {31'b0, oBusy},  32'h0);

    // Basic frame
    fr_acts = '{8'd1, 8'd2, 8'd3, 8'd4};
    en_pulses = 0;
    run_frame(8'd3, 0, 0, got, lat);
    check("basic_sum",     {8'b0, got}, 32'd30);
    check("basic_model",   {8'b0, ACC_W'(m_sum)}, 32'd30);
    check("basic_latency", lat, 5);
    check("basic_en",      en_pulses, 4);

    // Signed extremes
    fr_acts = '{8'h80, 8'h80, 8'h80, 8'h80};
    run_frame(8'h80, 0, 0, got, lat);
    check("ext_pos", {8'b0, got}, 32'h010000);
    run_frame(8'h7F, 0, 0, got, lat);
    check("ext_neg", {8'b0, got}, 32'hFF0200);
    check("ext_neg_model", {8'b0, ACC_W'(m_sum)}, 32'hFF0200);

    // Bubbles
    fr_acts = '{8'd1, 8'd2, 8'd3, 8'd4};
    en_pulses = 0;
    run_frame(8'hFE, 1, 0, got, lat);
    check("bubble_sum", {8'b0, got}, 32'hFFFFEC);
    check("bubble_en",  en_pulses, 4);

    // Output backpressure, then a frame right after
    fr_acts = '{8'd10, 8'd20, 8'd30, 8'd40};
    run_frame(8'd5, 0, 10, got, lat);
    check("bp_sum", {8'b0, got}, 32'd500);
    fr_acts = '{8'd1, 8'd1, 8'd1, 8'd1};
    run_frame(8'hFF, 0, 0, got, lat);
    check("bp_next_sum", {8'b0, got}, 32'hFFFFFC);

    // Reset in the middle of a frame
    iWtVld = 1'b1;
    iWt    = 8'd3;
    @(negedge clk);
    iWtVld  = 1'b0;
    iActVld = 1'b1;
    iAct    = 8'd9;
    @(negedge clk);
    @(negedge clk);
    iActVld = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_acc",    {8'b0, oAcc},     32'h0);
    check("midrst_busy",   {31'b0, oBusy},   32'h0);
    check("midrst_wt_rdy", {31'b0, oWtRdy},  32'h1);
    fr_acts = '{8'd5, 8'd5, 8'd5, 8'd5};
    run_frame(8'd1, 0, 0, got, lat);
    check("midrst_next_sum", {8'b0, got}, 32'd20);

    // Random frames
    for (int f = 0; f < 12; f++) begin
      rw = 8'($urandom);
      for (int i = 0; i < LEN; i++) fr_acts[i] = 8'($urandom);
      run_frame(rw, 2, $urandom_range(0, 3), got, lat);
      check("rand_sum", {8'b0, got}, {8'b0, frame_sum(rw)});
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
